// File: rtl/prof_pkg.sv
// Shared types for the ap_ctrl_hs handshake profiler: FSM state encoding,
// the record layout and a saturating counter helper.
// Record fields are sized for the widest supported CNT_W (PROF_MAX_CNT_W);
// instances with a narrower CNT_W zero-extend into them.
package prof_pkg;

  localparam int unsigned PROF_MAX_CNT_W = 64;
  localparam int unsigned PROF_TXN_W     = 16;

  typedef enum logic {
    PROF_IDLE   = 1'b0,
    PROF_ACTIVE = 1'b1
  } prof_state_e;

  typedef struct packed {
    logic [PROF_TXN_W-1:0]     txn_id;
    logic [PROF_MAX_CNT_W-1:0] latency;
    logic [PROF_MAX_CNT_W-1:0] interval;
    logic [PROF_MAX_CNT_W-1:0] stall;
  } prof_rec_t;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/prof_sync_fifo.sv
// Synchronous FIFO with full/empty/level flags. A push while full is
// accepted when a pop happens in the same cycle. DEPTH must be a power of 2
// and at least 2.
module prof_sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         data_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         data_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [AW:0]      cnt_q;
  logic             do_push;
  logic             do_pop;

  assign full_o  = (cnt_q == (AW+1)'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign count_o = cnt_q;
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);
  assign data_o  = mem_q[rd_ptr_q];

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({do_push, do_pop})
        2'b10:   cnt_q <= cnt_q + (AW+1)'(1);
        2'b01:   cnt_q <= cnt_q - (AW+1)'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  // Storage array; contents are don't-care while empty.
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= data_i;
  end

endmodule

// File: rtl/ap_hs_profiler.sv
// Passive profiler for an ap_ctrl_hs kernel interface. Timestamps every
// accepted start, pairs it with the matching done (in order) and emits one
// record per transaction: id, latency, start-to-start interval and, when
// AP_HS_PROFILER_STALL_EN is defined, the cycles start waited for ready.
module ap_hs_profiler
  import prof_pkg::*;
#(
  parameter int unsigned CNT_W       = 32,
  parameter int unsigned OUTST_DEPTH = 4,
  parameter int unsigned REC_DEPTH   = 8
) (
  input  logic             ap_clk,
  input  logic             ap_rst_n,
  input  logic             mon_ap_start,
  input  logic             mon_ap_ready,
  input  logic             mon_ap_done,
  input  logic             mon_ap_continue,
  output logic             rec_valid,
  input  logic             rec_ready,
  output logic [15:0]      rec_txn_id,
  output logic [CNT_W-1:0] rec_latency,
  output logic [CNT_W-1:0] rec_interval,
  output logic [CNT_W-1:0] rec_stall,
  output logic [15:0]      drop_cnt,
  output logic             outst_err,
  output logic             busy
);

  localparam int unsigned OQ_CW = $clog2(OUTST_DEPTH) + 1;
  localparam int unsigned RQ_CW = $clog2(REC_DEPTH) + 1;
`ifdef AP_HS_PROFILER_STALL_EN
  localparam int unsigned OQ_W = 3 * CNT_W;
`else
  localparam int unsigned OQ_W = 2 * CNT_W;
`endif

  logic [CNT_W-1:0] ts_q;
  logic [CNT_W-1:0] prev_start_q;
  logic             seen_start_q;
  logic [CNT_W-1:0] iv_now;

  logic             accept;
  logic             done_ev;
  logic             bypass;
  logic             form_valid;
  logic             err_ev;

  logic [OQ_W-1:0]  oq_wdata;
  logic [OQ_W-1:0]  oq_rdata;
  logic             oq_push;
  logic             oq_pop;
  logic             oq_push_ok;
  logic             oq_full;
  logic             oq_empty;
  logic [OQ_CW-1:0] oq_cnt;
  logic             oq_last;
  logic [CNT_W-1:0] head_ts;
  logic [CNT_W-1:0] head_iv;

  prof_state_e      state_q;
  logic             busy_q;

  logic [15:0]      txn_q;
  logic             pend_valid_q;
  prof_rec_t        pend_rec_q;
  prof_rec_t        form_rec;
  logic [CNT_W-1:0] form_lat;
  logic [CNT_W-1:0] form_iv;

  prof_rec_t        rq_rdata;
  logic             rq_full;
  logic             rq_empty;
  logic [RQ_CW-1:0] rq_cnt_unused;
  logic             rec_pop;
  logic             rec_drop;
  logic [15:0]      drop_cnt_q;
  logic             outst_err_q;
  logic             rec_hi_unused;

  assign accept  = mon_ap_start && mon_ap_ready;
  assign done_ev = mon_ap_done && mon_ap_continue;
  assign iv_now  = seen_start_q ? (ts_q - prev_start_q) : '0;

  // A done against an empty queue is only legal if the matching start is
  // accepted in the same cycle; that transaction never enters the queue.
  assign bypass     = accept && done_ev && oq_empty;
  assign oq_pop     = done_ev && !oq_empty;
  assign oq_push    = accept && !bypass;
  assign oq_push_ok = oq_push && (!oq_full || oq_pop);
  assign oq_last    = oq_pop && !oq_push_ok && (oq_cnt == OQ_CW'(1));
  assign form_valid = oq_pop || bypass;
  assign err_ev     = (oq_push && oq_full && !oq_pop) ||
                      (done_ev && oq_empty && !accept);

  assign head_ts = oq_rdata[OQ_W-1 -: CNT_W];
  assign head_iv = oq_rdata[OQ_W-CNT_W-1 -: CNT_W];

`ifdef AP_HS_PROFILER_STALL_EN
  logic [CNT_W-1:0] stall_q;
  logic [CNT_W-1:0] head_st;
  logic [CNT_W-1:0] form_st;

  assign head_st  = oq_rdata[CNT_W-1:0];
  assign oq_wdata = {ts_q, iv_now, stall_q};

  // Cycles start has been presented without ready since the last accept.
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      stall_q <= '0;
    end else if (accept) begin
      stall_q <= '0;
    end else if (mon_ap_start && !mon_ap_ready) begin
      stall_q <= stall_q + CNT_W'(1);
    end
  end
`else
  assign oq_wdata = {ts_q, iv_now};
`endif

  // Free-running timestamp and last-start tracking for the interval field.
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      ts_q         <= '0;
      prev_start_q <= '0;
      seen_start_q <= 1'b0;
    end else begin
      ts_q <= ts_q + CNT_W'(1);
      if (accept) begin
        prev_start_q <= ts_q;
        seen_start_q <= 1'b1;
      end
    end
  end

  prof_sync_fifo #(
    .WIDTH (OQ_W),
    .DEPTH (OUTST_DEPTH)
  ) u_outst_q (
    .clk_i   (ap_clk),
    .rst_ni  (ap_rst_n),
    .push_i  (oq_push),
    .data_i  (oq_wdata),
    .pop_i   (oq_pop),
    .data_o  (oq_rdata),
    .full_o  (oq_full),
    .empty_o (oq_empty),
    .count_o (oq_cnt)
  );

  // IDLE while nothing is outstanding, ACTIVE otherwise; busy is registered.
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      state_q <= PROF_IDLE;
      busy_q  <= 1'b0;
    end else begin
      case (state_q)
        PROF_IDLE: begin
          if (oq_push_ok) begin
            state_q <= PROF_ACTIVE;
            busy_q  <= 1'b1;
          end
        end
        PROF_ACTIVE: begin
          if (oq_last) begin
            state_q <= PROF_IDLE;
            busy_q  <= 1'b0;
          end
        end
        default: begin
          state_q <= PROF_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  // Assemble the record for the transaction completing this cycle.
  always_comb begin
    form_rec = '0;
    form_lat = ts_q - head_ts;
    form_iv  = head_iv;
`ifdef AP_HS_PROFILER_STALL_EN
    form_st  = head_st;
`endif
    if (bypass) begin
      form_lat = '0;
      form_iv  = iv_now;
`ifdef AP_HS_PROFILER_STALL_EN
      form_st  = stall_q;
`endif
    end
    form_rec.txn_id   = txn_q;
    form_rec.latency  = PROF_MAX_CNT_W'(form_lat);
    form_rec.interval = PROF_MAX_CNT_W'(form_iv);
`ifdef AP_HS_PROFILER_STALL_EN
    form_rec.stall    = PROF_MAX_CNT_W'(form_st);
`endif
  end

  assign rec_pop  = rec_valid && rec_ready;
  assign rec_drop = pend_valid_q && rq_full && !rec_pop;

  // Stage the record one cycle, then account ids, drops and errors.
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      pend_valid_q <= 1'b0;
      pend_rec_q   <= '0;
      txn_q        <= '0;
      drop_cnt_q   <= '0;
      outst_err_q  <= 1'b0;
    end else begin
      pend_valid_q <= form_valid;
      if (form_valid) begin
        pend_rec_q <= form_rec;
        txn_q      <= txn_q + 16'd1;
      end
      if (rec_drop) drop_cnt_q  <= sat_inc16(drop_cnt_q);
      if (err_ev)   outst_err_q <= 1'b1;
    end
  end

  prof_sync_fifo #(
    .WIDTH ($bits(prof_rec_t)),
    .DEPTH (REC_DEPTH)
  ) u_rec_q (
    .clk_i   (ap_clk),
    .rst_ni  (ap_rst_n),
    .push_i  (pend_valid_q),
    .data_i  (pend_rec_q),
    .pop_i   (rec_pop),
    .data_o  (rq_rdata),
    .full_o  (rq_full),
    .empty_o (rq_empty),
    .count_o (rq_cnt_unused)
  );

  // Bits above CNT_W are always zero-filled on write.
  assign rec_hi_unused = ^{rq_rdata.latency, rq_rdata.interval, rq_rdata.stall};

  assign rec_valid    = !rq_empty;
  assign rec_txn_id   = rec_valid ? rq_rdata.txn_id : '0;
  assign rec_latency  = rec_valid ? rq_rdata.latency[CNT_W-1:0] : '0;
  assign rec_interval = rec_valid ? rq_rdata.interval[CNT_W-1:0] : '0;
`ifdef AP_HS_PROFILER_STALL_EN
  assign rec_stall    = rec_valid ? rq_rdata.stall[CNT_W-1:0] : '0;
`else
  assign rec_stall    = '0;
`endif
  assign drop_cnt     = drop_cnt_q;
  assign outst_err    = outst_err_q;
  assign busy         = busy_q;

endmodule

// File: tb/tb_ap_hs_profiler.sv
// Scoreboard bench for ap_hs_profiler: a behavioural model of the
// outstanding queue forms expected records; records are checked as the DUT
// hands them over on rec_valid & rec_ready.
`timescale 1ns/1ps
module tb_ap_hs_profiler;

  localparam int unsigned CNT_W       = 32;
  localparam int unsigned OUTST_DEPTH = 4;
  localparam int unsigned REC_DEPTH   = 8;
`ifdef AP_HS_PROFILER_STALL_EN
  localparam bit STALL_EN = 1'b1;
`else
  localparam bit STALL_EN = 1'b0;
`endif

  logic             ap_clk = 1'b0;
  logic             ap_rst_n = 1'b1;
  logic             mon_ap_start = 1'b0;
  logic             mon_ap_ready = 1'b0;
  logic             mon_ap_done = 1'b0;
  logic             mon_ap_continue = 1'b1;
  logic             rec_ready = 1'b0;
  logic             rec_valid;
  logic [15:0]      rec_txn_id;
  logic [CNT_W-1:0] rec_latency;
  logic [CNT_W-1:0] rec_interval;
  logic [CNT_W-1:0] rec_stall;
  logic [15:0]      drop_cnt;
  logic             outst_err;
  logic             busy;

  ap_hs_profiler #(
    .CNT_W       (CNT_W),
    .OUTST_DEPTH (OUTST_DEPTH),
    .REC_DEPTH   (REC_DEPTH)
  ) dut (
    .ap_clk          (ap_clk),
    .ap_rst_n        (ap_rst_n),
    .mon_ap_start    (mon_ap_start),
    .mon_ap_ready    (mon_ap_ready),
    .mon_ap_done     (mon_ap_done),
    .mon_ap_continue (mon_ap_continue),
    .rec_valid       (rec_valid),
    .rec_ready       (rec_ready),
    .rec_txn_id      (rec_txn_id),
    .rec_latency     (rec_latency),
    .rec_interval    (rec_interval),
    .rec_stall       (rec_stall),
    .drop_cnt        (drop_cnt),
    .outst_err       (outst_err),
    .busy            (busy)
  );

  always #5 ap_clk = ~ap_clk;

  typedef struct {
    logic [15:0] txn;
    logic [31:0] lat;
    logic [31:0] iv;
    logic [31:0] st;
  } exp_rec_t;

  typedef struct {
    logic [31:0] ts;
    logic [31:0] iv;
    logic [31:0] st;
  } oq_ent_t;

  exp_rec_t    exp_q[$];
  oq_ent_t     oq[$];
  int unsigned n_vec = 0;
  int unsigned n_err = 0;
  logic [31:0] tb_cyc;
  logic [31:0] prev_start;
  logic [31:0] tb_stall;
  logic        first_start;
  logic [15:0] exp_txn;
  logic [15:0] exp_drop;
  logic        exp_err;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_clear();
    exp_q.delete();
    oq.delete();
    tb_cyc      = '0;
    prev_start  = '0;
    tb_stall    = '0;
    first_start = 1'b1;
    exp_txn     = '0;
    exp_drop    = '0;
    exp_err     = 1'b0;
  endtask

  task automatic form_exp(input oq_ent_t h);
    exp_rec_t e;
    e.txn   = exp_txn;
    e.lat   = tb_cyc - h.ts;
    e.iv    = h.iv;
    e.st    = h.st;
    exp_txn = exp_txn + 16'd1;
    if (exp_q.size() >= REC_DEPTH) exp_drop = exp_drop + 16'd1;
    else exp_q.push_back(e);
  endtask

  // One clock cycle: drive inputs, score any record handshake, update model.
  task automatic tick(input logic s, input logic r, input logic d, input logic c, input logic rr);
    logic     acc;
    logic     dn;
    logic     byp;
    oq_ent_t  ent;
    oq_ent_t  h;
    exp_rec_t e;
    mon_ap_start    = s;
    mon_ap_ready    = r;
    mon_ap_done     = d;
    mon_ap_continue = c;
    rec_ready       = rr;
    #1;
    if (rec_valid && rec_ready) begin
      check_eq("sb_pending", 64'(exp_q.size() != 0), 64'd1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check_eq("txn_id",   rec_txn_id,   e.txn);
        check_eq("latency",  rec_latency,  e.lat);
        check_eq("interval", rec_interval, e.iv);
        check_eq("stall",    rec_stall,    e.st);
      end
    end
    acc    = s && r;
    dn     = d && c;
    byp    = 1'b0;
    ent.ts = tb_cyc;
    ent.iv = first_start ? 32'd0 : tb_cyc - prev_start;
    ent.st = STALL_EN ? tb_stall : 32'd0;
    if (dn) begin
      if (oq.size() != 0) begin
        h = oq.pop_front();
        form_exp(h);
      end else if (acc) begin
        byp = 1'b1;
        form_exp(ent);
      end else begin
        exp_err = 1'b1;
      end
    end
    if (acc) begin
      if (!byp) begin
        if (oq.size() < OUTST_DEPTH) oq.push_back(ent);
        else exp_err = 1'b1;
      end
      prev_start  = tb_cyc;
      first_start = 1'b0;
      tb_stall    = '0;
    end else if (s && !r) begin
      tb_stall = tb_stall + 32'd1;
    end
    @(posedge ap_clk);
    #1;
    tb_cyc = tb_cyc + 32'd1;
  endtask

  task automatic apply_reset(input int unsigned n);
    ap_rst_n        = 1'b0;
    mon_ap_start    = 1'b0;
    mon_ap_ready    = 1'b0;
    mon_ap_done     = 1'b0;
    mon_ap_continue = 1'b1;
    rec_ready       = 1'b0;
    repeat (n) @(posedge ap_clk);
    #1;
    check_eq("rst_rec_valid", rec_valid,    0);
    check_eq("rst_busy",      busy,         0);
    check_eq("rst_outst_err", outst_err,    0);
    check_eq("rst_drop_cnt",  drop_cnt,     0);
    check_eq("rst_txn_id",    rec_txn_id,   0);
    check_eq("rst_latency",   rec_latency,  0);
    check_eq("rst_interval",  rec_interval, 0);
    check_eq("rst_stall",     rec_stall,    0);
    model_clear();
    ap_rst_n = 1'b1;
  endtask

  task automatic idle_until(input logic [31:0] cyc);
    while (tb_cyc < cyc) tick(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
  endtask

  task automatic drain(input int unsigned budget);
    int unsigned k = 0;
    while ((exp_q.size() != 0 || rec_valid) && k < budget) begin
      tick(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
      k++;
    end
    check_eq("drain_left", exp_q.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    model_clear();
    apply_reset(3);

    // Single transaction: accept at 10, done at 25.
    idle_until(10);
    tick(1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
    idle_until(25);
    check_eq("t1_busy_mid", busy, 1);
    tick(1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
    check_eq("t1_rv_early", rec_valid, 0);
    tick(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    check_eq("t1_rv_due", rec_valid, 1);
    drain(20);
    check_eq("t1_busy_end", busy, 0);

    // Pipelined: accepts at 10,12,14, dones at 20,22,24.
    apply_reset(2);
    idle_until(10);
    for (int i = 10; i <= 24; i++) begin
      if (i == 20) check_eq("t2_busy_mid", busy, 1);
      tick(((i <= 14) && (i % 2 == 0)) ? 1'b1 : 1'b0, 1'b1,
           ((i >= 20) && (i % 2 == 0)) ? 1'b1 : 1'b0, 1'b1, 1'b1);
    end
    check_eq("t2_busy_end", busy, 0);
    drain(20);

    // Stall: start held 5..8 without ready, accepted at 9, done at 12.
    apply_reset(2);
    idle_until(5);
    repeat (4) tick(1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
    tick(1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
    idle_until(12);
    tick(1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
    drain(20);

    // Bypass with empty queue, overlap pop/push, done gated by continue.
    tick(1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
    check_eq("byp_busy", busy, 0);
    tick(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    tick(1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
    repeat (3) tick(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    tick(1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
    tick(1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    check_eq("cont_busy", busy, 1);
    repeat (2) tick(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    tick(1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
    drain(20);
    check_eq("ovl_err", outst_err, exp_err);

    // Backpressure: ten transactions into an eight-deep record FIFO.
    apply_reset(2);
    for (int k = 0; k < 10; k++) begin
      tick(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
      tick(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    end
    repeat (2) tick(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    check_eq("bp_drop_cnt", drop_cnt, exp_drop);
    check_eq("bp_head_txn", rec_txn_id, 0);
    repeat (3) tick(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    check_eq("bp_hold_txn", rec_txn_id, 0);
    check_eq("bp_hold_vld", rec_valid, 1);
    drain(40);
    check_eq("bp_drop_end", drop_cnt, exp_drop);

    // Done with nothing outstanding.
    apply_reset(2);
    tick(1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
    repeat (3) tick(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    check_eq("err_empty", outst_err, exp_err);
    check_eq("err_norec", rec_valid, 0);

    // Outstanding queue overflow on the fifth accept.
    apply_reset(2);
    repeat (4) tick(1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
    check_eq("err_four", outst_err, exp_err);
    tick(1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
    check_eq("err_full", outst_err, exp_err);
    check_eq("full_busy", busy, 1);
    repeat (4) tick(1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
    drain(20);
    check_eq("full_busy_end", busy, 0);

    // Reset with two transactions in flight.
    apply_reset(2);
    repeat (2) tick(1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
    check_eq("mid_busy", busy, 1);
    apply_reset(3);
    tick(1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
    repeat (3) tick(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    check_eq("mid_err", outst_err, exp_err);
    check_eq("mid_norec", rec_valid, 0);
    drain(10);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/ap_hs_profiler.md
AP_HS_PROFILER -- requirements
Module: ap_hs_profiler

Interface
REQ-001 SHALL have parameter CNT_W, default 32: width of timestamp, latency and interval fields.
REQ-002 SHALL have parameter OUTST_DEPTH, default 4: maximum outstanding started-but-not-done transactions (power of 2).
REQ-003 SHALL have parameter REC_DEPTH, default 8: record FIFO depth (power of 2).
REQ-004 SHALL have these ports, one per line:
- ap_clk  in  1  single clock.
- ap_rst_n  in  1  asynchronous, active-low reset.
- mon_ap_start  in  1  observed kernel ap_start.
- mon_ap_ready  in  1  observed kernel ap_ready.
- mon_ap_done  in  1  observed kernel ap_done.
- mon_ap_continue  in  1  observed ap_continue (tie 1 for ap_ctrl_hs).
- rec_valid  out  1  record available.
- rec_ready  in  1  consumer accepts record.
- rec_txn_id  out  16  transaction index, wraps at 65535->0.
- rec_latency  out  CNT_W  done timestamp minus start timestamp.
- rec_interval  out  CNT_W  start timestamp minus previous start timestamp (0 for first).
- rec_stall  out  CNT_W  cycles start was held without ready before acceptance.
- drop_cnt  out  16  records lost to full FIFO, saturating.
- outst_err  out  1  sticky: start accepted while outstanding queue full, or done with queue empty.
- busy  out  1  at least one transaction outstanding.

Function
REQ-005 SHALL run a free-running CNT_W timestamp, +1 per cycle, wrapping; all differences modulo 2^CNT_W.
REQ-006 SHALL treat start accepted when mon_ap_start & mon_ap_ready in a cycle; push {timestamp, stall count} into outstanding queue.
REQ-007 SHALL treat done when mon_ap_done & mon_ap_continue; pop oldest entry and form one record.
REQ-008 SHALL handle accept and done in the same cycle: pop old head and push new entry; same-cycle start and done of a fresh transaction with empty queue SHALL produce latency 0 (bypass).
REQ-009 SHALL keep a two-state FSM, IDLE (queue empty) and ACTIVE (queue non-empty); busy = ACTIVE.
REQ-010 SHALL write a record into the record FIFO in the cycle after done (latency 1); rec_valid rises the following cycle at earliest.
REQ-011 SHALL hold record outputs stable while rec_valid & !rec_ready; pop on rec_valid & rec_ready; FIFO full + simultaneous pop SHALL accept the write.
REQ-012 SHALL drop the record and increment drop_cnt (saturating at 16'hFFFF) when the FIFO is full without a pop; txn_id still increments.
REQ-013 SHALL on queue-full accept set outst_err and ignore the push; on done with empty queue set outst_err and emit no record.
REQ-014 SHALL reset the stall counter on each accepted start; it counts cycles with mon_ap_start & !mon_ap_ready.

Reset
REQ-015 SHALL on ap_rst_n low clear timestamp, queues, FSM (IDLE), txn_id, drop_cnt, outst_err; rec_valid=0, busy=0, record fields 0.
REQ-016 SHALL discard all in-flight transactions and records on reset mid-operation; the first post-reset done with no accepted start sets outst_err.

Configuration
REQ-017 SHALL with AP_HS_PROFILER_STALL_EN defined implement the stall counter and drive rec_stall; without it rec_stall SHALL be constant 0 and no stall logic SHALL exist.

Structure
REQ-018 SHALL take the record struct type (txn_id, latency, interval, stall) and the FSM state enum from package prof_pkg.
REQ-019 SHALL instantiate sub-module prof_sync_fifo (parameterised width/depth, full/empty, same-cycle push/pop) for both the outstanding queue and the record FIFO.

Verification
REQ-020 Single transaction: accept at t=10, done at t=25, rec_ready=1 -> one record, txn_id 0, latency 15, interval 0.
REQ-021 Back-to-back pipelined: accepts at t=10,12,14, dones at 20,22,24 -> latencies 10,10,10, intervals 0,2,2, busy low after t=24.
REQ-022 Backpressure: rec_ready=0, 10 transactions with REC_DEPTH=8 -> 8 records retained, drop_cnt=2, txn_ids 0..7 read out after release.
REQ-023 Stall (macro defined): start high t=5..9, ready only at t=9 -> rec_stall=4; macro undefined -> rec_stall=0.
REQ-024 Errors: done with empty queue -> outst_err=1, no record; 5 accepts without done (OUTST_DEPTH=4) -> outst_err=1.
REQ-025 Reset mid-operation: 2 outstanding, assert ap_rst_n=0 for 3 cycles -> all outputs reset values, rec_valid=0, busy=0.
